av_sprite_fetch_arbiter: RTL and testbench
==========================================

// Module: av_sprite_fetch_arbiter
// PURPOSE
//  Shares one sprite-ROM bank among NUM_CH string renderers. It replaces the OR-ed paddr
//  scheme, in which only one string could address the bank at a time.
//  Per-channel valid/ready request port; round-robin or fixed-priority arbitration with
//  anti-starvation aging. Pipelined bank address, delayed sprite-word select, and returned
//  pixel data tagged one-hot to the requesting channel.
//  Sits in the AV block between the AV_string instances and the inferred fret_xx BRAMs.
// PARAMETERS
//  NUM_CH       6   requesting channels (strings)
//  ADDR_W       10  sprite word address width
//  PIX_W        13  sprite pixel word width
//  NUM_SPRITES  16  sprite words presented in parallel on mem_rdata
//  SEL_W        5   sprite select width; must satisfy 2**SEL_W >= NUM_SPRITES
//  MEM_LAT      1   bank read latency in cycles (mem_en cycle k -> mem_rdata valid in cycle k+MEM_LAT), >=1
//  MAX_WAIT     8   wait-counter saturation value that forces a grant (aging), >=1
// PORTS
//  clk65     in   1                   pixel clock; the only clock
//  reset     in   1                   synchronous, active-high
//  arb_mode  in   1                   0 = round-robin, 1 = fixed priority (ch0 highest)
//  req       in   NUM_CH              per-channel request valid
//  req_addr  in   NUM_CH*ADDR_W       per-channel word address; ch i at [i*ADDR_W +: ADDR_W]
//  req_sel   in   NUM_CH*SEL_W        per-channel sprite select; ch i at [i*SEL_W +: SEL_W]
//  gnt       out  NUM_CH              one-hot ready; transfer on the edge where req[i]&gnt[i]
//  mem_en    out  1                   bank read enable
//  mem_addr  out  ADDR_W              bank read address
//  mem_rdata in   NUM_SPRITES*PIX_W   all sprite words at mem_addr; sprite s at [s*PIX_W +: PIX_W]
//  rd_data   out  PIX_W               returned pixel word
//  rd_valid  out  NUM_CH              one-hot owner of rd_data, 1-cycle pulse
// BEHAVIOUR
//  - Reset values: gnt=0 (forced 0 while reset is high), mem_en=0, mem_addr=0, rd_data=0,
//    rd_valid=0. Internal state also clears: rr_ptr=0, all wait counters=0, tag/select pipe empty.
//  - gnt is combinational from req, arb_mode, rr_ptr and the wait counters.
//    At most one bit is set. gnt is 0 when req==0. At most one transfer per cycle.
//  - Winner selection, first rule that applies:
//    (a) aging: lowest-index channel with wait_cnt==MAX_WAIT and req high;
//    (b) arb_mode=1: lowest-index requester;
//    (c) arb_mode=0: first requester searching upward from rr_ptr, wrapping NUM_CH-1 -> 0.
//  - rr_ptr <= (winner+1) mod NUM_CH on every transfer, in both modes; unchanged otherwise.
//  - wait_cnt[i]: cleared when req[i]=0 or gnt[i]=1; otherwise +1, saturating at MAX_WAIT.
//  - Transfer in cycle t -> cycle t+1: mem_en=1, mem_addr=req_addr[winner].
//    The winner one-hot tag and req_sel are also captured into a (MEM_LAT+1)-deep pipe.
//  - Cycle t+1+MEM_LAT: selection of mem_rdata by the delayed sel is registered.
//    Cycle t+2+MEM_LAT: rd_valid=tag, rd_data=selected word.
//    Fixed latency gnt->rd_valid = MEM_LAT+2 cycles (3 at default).
//  - No transfer -> mem_en=0 and mem_addr holds its last value; rd_valid=0 in the matching
//    output cycle; rd_data holds its last value.
//  - sel >= NUM_SPRITES: rd_data=0, and rd_valid is still asserted for the owner.
//  - Back-to-back: a channel holding req high after its gnt presents a new request. Returns
//    stay in grant order, one per cycle; there is no backpressure on the return path.
//  - arb_mode may change on any cycle and takes effect combinationally on that cycle's grant.
//    rr_ptr and the wait counters are not disturbed.
//  - reset mid-operation: all in-flight reads are dropped; no rd_valid pulse occurs for
//    transfers made before reset.
//  - Arithmetic: wait counters are clog2(MAX_WAIT+1) bits wide; rr_ptr is clog2(NUM_CH) bits wide.
// TESTING
//  1. Only ch2 requests, addr=0x005, sel=3 -> gnt=6'b000100 same cycle.
//     Next cycle mem_en=1, mem_addr=0x005. Three cycles after gnt: rd_valid=6'b000100,
//     rd_data=word 3 of mem_rdata.
//  2. arb_mode=0, req=6'b111111 held 12 cycles -> grant order 0,1,2,3,4,5,0,1,2,3,4,5.
//     rd_valid follows the same order 3 cycles later, one pulse per cycle.
//  3. arb_mode=1, req=6'b100001 held -> ch0 is granted for 8 cycles, ch5 on the 9th
//     (aging, MAX_WAIT=8), then ch0 again; ch5's wait counter restarts at 0.
//  4. Grant ch1 and ch3 on consecutive cycles, assert reset for 1 cycle on the next cycle
//     -> no rd_valid ever appears for either. After reset, the first RR grant with
//     req=6'b111111 goes to ch0.
//  5. ch4 requests with sel=17 (NUM_SPRITES=16) -> rd_valid=6'b010000 with rd_data=0.
//  6. arb_mode 0 -> 1 mid-stream with req=6'b111111, rr_ptr=3 -> the next grant is ch0
//     (not ch3). Switching back to mode 0 -> the next grant is ch1.

Source files
------------

// File: rtl/av_sprite_fetch_arbiter_if.sv
// Bus bundle between the string renderers, the sprite-ROM bank and the fetch arbiter.
// The arbiter uses the slave view; the renderers/bank side uses the master view.
interface av_sprite_fetch_arbiter_if #(
    parameter int NUM_CH      = 6,
    parameter int ADDR_W      = 10,
    parameter int PIX_W       = 13,
    parameter int NUM_SPRITES = 16,
    parameter int SEL_W       = 5
);
    logic [NUM_CH-1:0]            req;
    logic [NUM_CH*ADDR_W-1:0]     req_addr;
    logic [NUM_CH*SEL_W-1:0]      req_sel;
    logic [NUM_CH-1:0]            gnt;
    logic                         mem_en;
    logic [ADDR_W-1:0]            mem_addr;
    logic [NUM_SPRITES*PIX_W-1:0] mem_rdata;
    logic [PIX_W-1:0]             rd_data;
    logic [NUM_CH-1:0]            rd_valid;

    modport slave (
        input  req, req_addr, req_sel, mem_rdata,
        output gnt, mem_en, mem_addr, rd_data, rd_valid
    );

    modport master (
        output req, req_addr, req_sel, mem_rdata,
        input  gnt, mem_en, mem_addr, rd_data, rd_valid
    );
endinterface

// File: rtl/av_sprite_fetch_arbiter.sv
// Shares one sprite-ROM bank among NUM_CH string renderers: aging/priority/round-robin
// grant, pipelined bank address and a fixed-latency, one-hot tagged pixel return.
module av_sprite_fetch_arbiter #(
    parameter int NUM_CH      = 6,
    parameter int ADDR_W      = 10,
    parameter int PIX_W       = 13,
    parameter int NUM_SPRITES = 16,
    parameter int SEL_W       = 5,
    parameter int MEM_LAT     = 1,
    parameter int MAX_WAIT    = 8
) (
    input logic clk65,
    input logic reset,
    input logic arb_mode,
    av_sprite_fetch_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int DEPTH = MEM_LAT + 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  wait_cnt [NUM_CH];
    logic [NUM_CH-1:0] tag_pipe [DEPTH];
    logic [SEL_W-1:0]  sel_pipe [DEPTH];

    logic [NUM_CH-1:0] gnt_c;
    logic [NUM_CH-1:0] req_rot;
    logic [PTR_W:0]    rr_sum;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  next_ptr;
    logic              found;
    logic              transfer;
    logic [ADDR_W-1:0] win_addr;
    logic [SEL_W-1:0]  win_sel;
    logic [PIX_W-1:0]  sel_word;

    // Winner pick: aged channel first, then fixed priority or round-robin from rr_ptr.
    always_comb begin
        gnt_c   = '0;
        winner  = '0;
        found   = 1'b0;
        rr_sum  = '0;
        req_rot = NUM_CH'({bus.req, bus.req} >> rr_ptr);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && bus.req[i] && wait_cnt[i] == CNT_W'(MAX_WAIT)) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
        if (!found && arb_mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && bus.req[i]) begin
                    found  = 1'b1;
                    winner = PTR_W'(i);
                end
            end
        end
        if (!found && !arb_mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req_rot[i]) begin
                    found  = 1'b1;
                    rr_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
                    if (rr_sum >= (PTR_W+1)'(NUM_CH))
                        rr_sum = rr_sum - (PTR_W+1)'(NUM_CH);
                    winner = rr_sum[PTR_W-1:0];
                end
            end
        end
        if (found && !reset)
            gnt_c[winner] = 1'b1;
    end

    assign bus.gnt  = gnt_c;
    assign transfer = |gnt_c;
    assign next_ptr = (winner == PTR_W'(NUM_CH - 1)) ? '0 : winner + PTR_W'(1);

    always_comb begin
        win_addr = '0;
        win_sel  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_c[i]) begin
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_sel  = bus.req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_word = '0;
        for (int s = 0; s < NUM_SPRITES; s++) begin
            if (sel_pipe[DEPTH-1] == SEL_W'(s))
                sel_word = bus.mem_rdata[s*PIX_W +: PIX_W];
        end
    end

    always_ff @(posedge clk65) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_CH; i++)
                wait_cnt[i] <= '0;
        end else begin
            if (transfer)
                rr_ptr <= next_ptr;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!bus.req[i] || gnt_c[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != CNT_W'(MAX_WAIT))
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Tag/select pipe lines up with the bank latency so returns stay in grant order.
    always_ff @(posedge clk65) begin
        if (reset) begin
            bus.mem_en   <= 1'b0;
            bus.mem_addr <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                tag_pipe[d] <= '0;
                sel_pipe[d] <= '0;
            end
        end else begin
            bus.mem_en <= transfer;
            if (transfer)
                bus.mem_addr <= win_addr;
            tag_pipe[0] <= gnt_c;
            sel_pipe[0] <= win_sel;
            for (int d = 1; d < DEPTH; d++) begin
                tag_pipe[d] <= tag_pipe[d-1];
                sel_pipe[d] <= sel_pipe[d-1];
            end
            bus.rd_valid <= tag_pipe[DEPTH-1];
            if (|tag_pipe[DEPTH-1])
                bus.rd_data <= sel_word;
        end
    end

endmodule

// File: tb/tb_av_sprite_fetch_arbiter.sv
// Directed bench for av_sprite_fetch_arbiter with a 1-cycle-latency sprite-ROM model.
module tb_av_sprite_fetch_arbiter;

    logic clk65 = 1'b0;
    logic reset;
    logic arb_mode;
    int   total = 0;
    int   bad   = 0;

    av_sprite_fetch_arbiter_if #(
        .NUM_CH(6), .ADDR_W(10), .PIX_W(13), .NUM_SPRITES(16), .SEL_W(5)
    ) bus ();

    av_sprite_fetch_arbiter #(
        .NUM_CH(6), .ADDR_W(10), .PIX_W(13), .NUM_SPRITES(16),
        .SEL_W(5), .MEM_LAT(1), .MAX_WAIT(8)
    ) dut (
        .clk65(clk65),
        .reset(reset),
        .arb_mode(arb_mode),
        .bus(bus)
    );

    always #5 clk65 = ~clk65;

    function automatic logic [12:0] word_at(input logic [9:0] a, input int s);
        logic [31:0] v;
        v = ({22'd0, a} << 4) + 32'(s);
        v = v ^ 32'h0000_00A5;
        return v[12:0];
    endfunction

    function automatic logic [207:0] row_at(input logic [9:0] a);
        logic [207:0] r;
        r = '0;
        for (int s = 0; s < 16; s++)
            r[s*13 +: 13] = word_at(a, s);
        return r;
    endfunction

    // Bank model: data for the address presented with mem_en appears one cycle later.
    always @(posedge clk65) begin
        if (bus.mem_en)
            bus.mem_rdata <= row_at(bus.mem_addr);
    end

    task automatic step();
        @(posedge clk65);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [9:0] a, input logic [4:0] s);
        bus.req_addr[ch*10 +: 10] = a;
        bus.req_sel[ch*5 +: 5]    = s;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        arb_mode = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        arb_mode = 1'b0;
        bus.req  = 6'b111111;
        step();
        #1;
        total++;
        if (bus.gnt !== 6'b000000) begin
            bad++; $display("FAIL reset_gnt got=%b exp=%b", bus.gnt, 6'b000000);
        end
        step();
        reset   = 1'b0;
        bus.req = '0;
        #1;
        total++;
        if (bus.mem_en !== 1'b0 || bus.mem_addr !== 10'h000) begin
            bad++; $display("FAIL reset_mem got=%b/%h exp=0/000", bus.mem_en, bus.mem_addr);
        end
        total++;
        if (bus.rd_valid !== 6'b000000 || bus.rd_data !== 13'h0000) begin
            bad++; $display("FAIL reset_rd got=%b/%h exp=000000/0000", bus.rd_valid, bus.rd_data);
        end
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_ch(2, 10'h005, 5'd3);
        bus.req = 6'b000100;
        #1;
        total++;
        if (bus.gnt !== 6'b000100) begin
            bad++; $display("FAIL single_gnt got=%b exp=%b", bus.gnt, 6'b000100);
        end
        step();
        bus.req = '0;
        #1;
        total++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'h005) begin
            bad++; $display("FAIL single_mem got=%b/%h exp=1/005", bus.mem_en, bus.mem_addr);
        end
        step();
        #1;
        total++;
        if (bus.mem_en !== 1'b0 || bus.mem_addr !== 10'h005 || bus.rd_valid !== 6'b000000) begin
            bad++; $display("FAIL single_idle got=%b/%h/%b exp=0/005/000000",
                            bus.mem_en, bus.mem_addr, bus.rd_valid);
        end
        step();
        #1;
        total++;
        if (bus.rd_valid !== 6'b000100 || bus.rd_data !== word_at(10'h005, 3)) begin
            bad++; $display("FAIL single_rd got=%b/%h exp=000100/%h",
                            bus.rd_valid, bus.rd_data, word_at(10'h005, 3));
        end
        step();
        #1;
        total++;
        if (bus.rd_valid !== 6'b000000 || bus.rd_data !== word_at(10'h005, 3)) begin
            bad++; $display("FAIL single_hold got=%b/%h exp=000000/%h",
                            bus.rd_valid, bus.rd_data, word_at(10'h005, 3));
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_g;
        int k;
        do_reset();
        for (int i = 0; i < 6; i++)
            set_ch(i, 10'h040 + 10'(i * 3), 5'(i + 1));
        for (int cyc = 0; cyc < 15; cyc++) begin
            bus.req = (cyc < 12) ? 6'b111111 : 6'b000000;
            #1;
            if (cyc < 12) begin
                exp_g = 6'b000001 << (cyc % 6);
                total++;
                if (bus.gnt !== exp_g) begin
                    bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_g);
                end
            end
            if (cyc >= 3) begin
                k = (cyc - 3) % 6;
                exp_g = 6'b000001 << k;
                total++;
                if (bus.rd_valid !== exp_g ||
                    bus.rd_data !== word_at(10'h040 + 10'(k * 3), k + 1)) begin
                    bad++; $display("FAIL rr_rd cyc=%0d got=%b/%h exp=%b/%h", cyc,
                                    bus.rd_valid, bus.rd_data, exp_g,
                                    word_at(10'h040 + 10'(k * 3), k + 1));
                end
            end
            step();
        end
    endtask

    task automatic test_aging();
        logic [5:0] exp_g;
        do_reset();
        arb_mode = 1'b1;
        bus.req  = 6'b100001;
        for (int cyc = 0; cyc < 19; cyc++) begin
            #1;
            exp_g = (cyc == 8 || cyc == 17) ? 6'b100000 : 6'b000001;
            total++;
            if (bus.gnt !== exp_g) begin
                bad++; $display("FAIL aging_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_g);
            end
            step();
        end
        bus.req  = '0;
        arb_mode = 1'b0;
    endtask

    task automatic test_reset_drop();
        do_reset();
        bus.req = 6'b000010;
        #1;
        total++;
        if (bus.gnt !== 6'b000010) begin
            bad++; $display("FAIL drop_gnt1 got=%b exp=%b", bus.gnt, 6'b000010);
        end
        step();
        bus.req = 6'b001000;
        #1;
        total++;
        if (bus.gnt !== 6'b001000) begin
            bad++; $display("FAIL drop_gnt3 got=%b exp=%b", bus.gnt, 6'b001000);
        end
        step();
        bus.req = '0;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            #1;
            total++;
            if (bus.rd_valid !== 6'b000000) begin
                bad++; $display("FAIL drop_rd cyc=%0d got=%b exp=000000", cyc, bus.rd_valid);
            end
            step();
        end
        bus.req = 6'b111111;
        #1;
        total++;
        if (bus.gnt !== 6'b000001) begin
            bad++; $display("FAIL drop_first_rr got=%b exp=%b", bus.gnt, 6'b000001);
        end
        step();
        bus.req = '0;
    endtask

    task automatic test_bad_sel();
        do_reset();
        set_ch(4, 10'h0AB, 5'd2);
        bus.req = 6'b010000;
        #1;
        total++;
        if (bus.gnt !== 6'b010000) begin
            bad++; $display("FAIL badsel_gnt_a got=%b exp=%b", bus.gnt, 6'b010000);
        end
        step();
        set_ch(4, 10'h0AB, 5'd17);
        #1;
        total++;
        if (bus.gnt !== 6'b010000) begin
            bad++; $display("FAIL badsel_gnt_b got=%b exp=%b", bus.gnt, 6'b010000);
        end
        step();
        bus.req = '0;
        step();
        #1;
        total++;
        if (bus.rd_valid !== 6'b010000 || bus.rd_data !== word_at(10'h0AB, 2)) begin
            bad++; $display("FAIL badsel_prev got=%b/%h exp=010000/%h",
                            bus.rd_valid, bus.rd_data, word_at(10'h0AB, 2));
        end
        step();
        #1;
        total++;
        if (bus.rd_valid !== 6'b010000 || bus.rd_data !== 13'h0000) begin
            bad++; $display("FAIL badsel_rd got=%b/%h exp=010000/0000", bus.rd_valid, bus.rd_data);
        end
        step();
    endtask

    task automatic test_mode_switch();
        logic [5:0] exp_g;
        do_reset();
        bus.req = 6'b111111;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_g = 6'b000001 << k;
            total++;
            if (bus.gnt !== exp_g) begin
                bad++; $display("FAIL mode_pre k=%0d got=%b exp=%b", k, bus.gnt, exp_g);
            end
            step();
        end
        arb_mode = 1'b1;
        #1;
        total++;
        if (bus.gnt !== 6'b000001) begin
            bad++; $display("FAIL mode_fixed got=%b exp=%b", bus.gnt, 6'b000001);
        end
        step();
        arb_mode = 1'b0;
        #1;
        total++;
        if (bus.gnt !== 6'b000010) begin
            bad++; $display("FAIL mode_back_rr got=%b exp=%b", bus.gnt, 6'b000010);
        end
        step();
        bus.req = '0;
    endtask

    initial begin
        reset         = 1'b1;
        arb_mode      = 1'b0;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_sel   = '0;
        bus.mem_rdata = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_aging();
        test_reset_drop();
        test_bad_sel();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
